// File: rtl/debug_display_mux_pkg.sv
// debug_pkg: shared constants, mode enum and one-hot decode helper for the
// debug display selector.
//   SEG_DASH / SEG_BLANK : active-low segment patterns for '-' and all-off
//   mode_e               : display mode decoded from the debounced switches
//   onehot_index()       : index of the single set bit, plus a one-hot flag
package debug_pkg;

  localparam logic [7:0]  SEG_DASH  = 8'hBF;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam int unsigned MAX_CH    = 16;

  typedef enum logic [1:0] {
    MODE_INVALID,
    MODE_MANUAL,
    MODE_SCROLL
  } mode_e;

  // ok is set only when exactly one bit of vec is high; idx is then its position.
  function automatic void onehot_index(input  logic [MAX_CH-1:0] vec,
                                       output int unsigned       idx,
                                       output logic              ok);
    int unsigned cnt;
    cnt = 0;
    idx = 0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (vec[i]) begin
        cnt = cnt + 1;
        idx = i;
      end
    end
    ok = (cnt == 1);
  endfunction

endpackage

// File: rtl/debug_display_mux_if.sv
// debug_display_mux_if: switch/digit inputs and display outputs of the
// debug display selector.
//   DSW    : [N_CH-1:0] one-hot channel select, [N_CH] scroll enable (async)
//   DIGITS : N_CH channels of N_DIG active-low digit patterns
//   SEG    : registered segment output of the shown channel
//   CH_IDX : channel currently shown
//   SCROLL : scroll mode active
//   VALID  : SEG shows a real channel
// master drives DSW/DIGITS, slave (the selector) drives the display side.
interface debug_display_mux_if #(
  parameter int unsigned N_CH  = 6,
  parameter int unsigned N_DIG = 2
);
  localparam int unsigned CH_W = $clog2(N_CH);

  logic [N_CH:0]            DSW;
  logic [N_CH*N_DIG*8-1:0]  DIGITS;
  logic [N_DIG*8-1:0]       SEG;
  logic [CH_W-1:0]          CH_IDX;
  logic                     SCROLL;
  logic                     VALID;

  modport master (output DSW, DIGITS, input  SEG, CH_IDX, SCROLL, VALID);
  modport slave  (input  DSW, DIGITS, output SEG, CH_IDX, SCROLL, VALID);
endinterface

// File: rtl/debug_display_mux_debounce.sv
// dsw_debounce: 2-FF synchroniser plus debounce for a bank of switches.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_async      : raw switch inputs (W bits)
//   o_stable     : accepted switch value, updated once the synchronised value
//                  has been constant for DEB_CYCLES cycles
module dsw_debounce #(
  parameter int unsigned W          = 7,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_stable
);
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [W-1:0]     r_s1;
  logic [W-1:0]     r_s2;
  logic [W-1:0]     r_cand;
  logic [W-1:0]     r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  // s2 has already been constant for one cycle on the edge where the
  // candidate catches up with it, so acceptance fires one count early.
  assign w_accept = (DEB_CYCLES <= 2) || (int'(r_cnt) + 1 >= int'(DEB_CYCLES) - 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_cand <= r_s2;
      if (DEB_CYCLES == 1) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else if (r_s2 != r_cand || r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;
endmodule

// File: rtl/debug_display_mux.sv
// debug_display_mux: selects one of N_CH measurement channels (N_DIG digits
// each) for the 7-segment display, by one-hot DIP switch or automatic scroll.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : debug_display_mux_if.slave (DSW, DIGITS in; SEG, CH_IDX,
//              SCROLL, VALID out, all outputs registered)
// Optional feature: define DEBUG_DISPLAY_BLINK_EN to blink dash/blank on an
// invalid selection (BLINK_HALF cycles per phase); otherwise steady dashes.
module debug_display_mux
  import debug_pkg::*;
#(
  parameter int unsigned N_CH       = 6,
  parameter int unsigned N_DIG      = 2,
  parameter int unsigned DWELL      = 100_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic                  CLK,
  input  logic                  RST,
  debug_display_mux_if.slave    bus
);
  localparam int unsigned SEG_W = N_DIG * 8;
  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned DW_W  = $clog2(DWELL);

  logic [N_CH:0]      w_stable;
  mode_e              w_mode;
  int unsigned        w_onehot_idx;
  logic               w_onehot_ok;
  logic [CH_W-1:0]    w_man_idx;
  logic [CH_W-1:0]    w_next_scroll_idx;
  logic [SEG_W-1:0]   w_seg_man;
  logic [SEG_W-1:0]   w_seg_scroll;
  logic [SEG_W-1:0]   w_seg_invalid;

  logic [SEG_W-1:0]   r_seg;
  logic [CH_W-1:0]    r_ch_idx;
  logic [DW_W-1:0]    r_dwell;
  logic               r_scroll;
  logic               r_valid;

  dsw_debounce #(
    .W          (N_CH + 1),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_async  (bus.DSW),
    .o_stable (w_stable)
  );

  always_comb begin
    w_onehot_idx = 0;
    w_onehot_ok  = 1'b0;
    onehot_index(MAX_CH'(w_stable[N_CH-1:0]), w_onehot_idx, w_onehot_ok);
    if (w_stable[N_CH])   w_mode = MODE_SCROLL;
    else if (w_onehot_ok) w_mode = MODE_MANUAL;
    else                  w_mode = MODE_INVALID;
  end

  assign w_man_idx         = CH_W'(w_onehot_idx);
  assign w_next_scroll_idx = (r_ch_idx == CH_W'(N_CH - 1)) ? '0 : r_ch_idx + CH_W'(1);
  assign w_seg_man         = bus.DIGITS[w_onehot_idx * SEG_W +: SEG_W];
  // Scroll shows the already-registered index, so SEG trails CH_IDX by one edge.
  assign w_seg_scroll      = bus.DIGITS[r_ch_idx * SEG_W +: SEG_W];

`ifdef DEBUG_DISPLAY_BLINK_EN
  localparam int unsigned BL_W = $clog2(BLINK_HALF + 1);

  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink_phase;

  // Held at dash phase outside the invalid mode so every entry starts on dashes.
  always_ff @(posedge CLK) begin
    if (RST || w_mode != MODE_INVALID) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BL_W'(BLINK_HALF - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BL_W'(1);
    end
  end

  assign w_seg_invalid = {N_DIG{r_blink_phase ? SEG_BLANK : SEG_DASH}};
`else
  assign w_seg_invalid = {N_DIG{SEG_DASH}};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_seg    <= {N_DIG{SEG_DASH}};
      r_ch_idx <= '0;
      r_dwell  <= '0;
      r_scroll <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_scroll <= (w_mode == MODE_SCROLL);
      unique case (w_mode)
        MODE_SCROLL: begin
          r_valid <= 1'b1;
          r_seg   <= w_seg_scroll;
          // r_scroll low here means the scroll bit has just been accepted.
          if (!r_scroll) begin
            r_ch_idx <= '0;
            r_dwell  <= '0;
          end else if (r_dwell == DW_W'(DWELL - 1)) begin
            r_dwell  <= '0;
            r_ch_idx <= w_next_scroll_idx;
          end else begin
            r_dwell <= r_dwell + DW_W'(1);
          end
        end
        MODE_MANUAL: begin
          r_valid  <= 1'b1;
          r_seg    <= w_seg_man;
          r_ch_idx <= w_man_idx;
          r_dwell  <= '0;
        end
        default: begin
          r_valid <= 1'b0;
          r_seg   <= w_seg_invalid;
          r_dwell <= '0;
        end
      endcase
    end
  end

  assign bus.SEG    = r_seg;
  assign bus.CH_IDX = r_ch_idx;
  assign bus.SCROLL = r_scroll;
  assign bus.VALID  = r_valid;
endmodule
